// File: rtl/power_level_select_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | power_level_select_if : front-panel buttons in, power mode/pulses out    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface power_level_select_if;
  logic       btn_up;
  logic       btn_down;
  logic       lock;
  logic [1:0] mode;
  logic       mode_changed;
  logic       reject;

  // The panel/controller side drives the buttons and lock.
  modport master (
    output btn_up,
    output btn_down,
    output lock,
    input  mode,
    input  mode_changed,
    input  reject
  );

  modport slave (
    input  btn_up,
    input  btn_down,
    input  lock,
    output mode,
    output mode_changed,
    output reject
  );
endinterface
`default_nettype wire

// File: rtl/power_level_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | power_level_select : debounced UP/DOWN buttons driving a 3-level power   |
// | mode FSM (01 low, 10 normal, 11 high), frozen while cooking.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module power_level_select #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  wire logic            clk,
  input  wire logic            reset,
  power_level_select_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_BAD  = 2'b00,
    S_LOW  = 2'b01,
    S_NORM = 2'b10,
    S_HIGH = 2'b11
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {bus.btn_down, bus.btn_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Press pulse fires on the same edge the debounced level rises.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_stable <= 1'b0;
        r_press  <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_s1    <= w_raw[gi];
        r_s2    <= r_s1;
        r_press <= 1'b0;
        if (r_s2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
          r_press  <= r_s2;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  logic   w_up;
  logic   w_dn;
  state_t r_state;
  state_t w_next;
  logic   r_changed;
  logic   w_changed;
  logic   r_reject;
  logic   w_reject;

  assign w_up = w_press[0];
  assign w_dn = w_press[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_NORM;
      r_changed <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= w_changed;
      r_reject  <= w_reject;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_changed = 1'b0;
    w_reject  = 1'b0;
    if (r_state == S_BAD) begin
      // Recover from a corrupted state register regardless of input.
      w_next    = S_NORM;
      w_changed = 1'b1;
    end else if (w_up || w_dn) begin
      if (bus.lock || (w_up && w_dn)) begin
        w_reject = 1'b1;
      end else if (w_up) begin
        case (r_state)
          S_LOW:   begin w_next = S_NORM; w_changed = 1'b1; end
          S_NORM:  begin w_next = S_HIGH; w_changed = 1'b1; end
          default: w_reject = 1'b1;
        endcase
      end else begin
        case (r_state)
          S_HIGH:  begin w_next = S_NORM; w_changed = 1'b1; end
          S_NORM:  begin w_next = S_LOW;  w_changed = 1'b1; end
          default: w_reject = 1'b1;
        endcase
      end
    end
  end

  assign bus.mode         = r_state;
  assign bus.mode_changed = r_changed;
  assign bus.reject       = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_power_level_select.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_power_level_select : directed bench for power_level_select            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_power_level_select;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  power_level_select_if bus ();

  power_level_select #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    for (int i = 0; i < ncyc; i++) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.lock = 1'b0;
    do_reset(3);
    n_vec++; if (bus.mode !== 2'b10) begin n_err++; $display("FAIL reset_mode: got %b want 10", bus.mode); end
    n_vec++; if (bus.mode_changed !== 1'b0) begin n_err++; $display("FAIL reset_changed: got %b want 0", bus.mode_changed); end
    n_vec++; if (bus.reject !== 1'b0) begin n_err++; $display("FAIL reset_reject: got %b want 0", bus.reject); end
  endtask

  // Idle with all buttons released; no pulse and a fixed mode expected.
  task automatic test_idle(input int ncyc, input logic [1:0] m, input string nm);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {m, 2'b00}) begin
        n_err++;
        $display("FAIL %s cyc %0d: got mode=%b chg=%b rej=%b want mode=%b chg=0 rej=0",
                 nm, j, bus.mode, bus.mode_changed, bus.reject, m);
      end
    end
  endtask

  task automatic test_up_press();
    logic [1:0] em;
    bus.btn_up = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      em = (j >= 6) ? 2'b11 : 2'b10;
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {em, (j == 6), 1'b0}) begin
        n_err++;
        $display("FAIL up1 cyc %0d: got mode=%b chg=%b rej=%b want mode=%b chg=%0d rej=0",
                 j, bus.mode, bus.mode_changed, bus.reject, em, (j == 6));
      end
    end
    test_idle(8, 2'b11, "up1_release");
    bus.btn_up = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {2'b11, 1'b0, (j == 6)}) begin
        n_err++;
        $display("FAIL up2_sat cyc %0d: got mode=%b chg=%b rej=%b want mode=11 chg=0 rej=%0d",
                 j, bus.mode, bus.mode_changed, bus.reject, (j == 6));
      end
    end
    test_idle(8, 2'b11, "up2_release");
  endtask

  task automatic test_bounce();
    do_reset(2);
    for (int j = 0; j < 16; j++) begin
      bus.btn_up = ((j / 2) % 2 == 0);
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== 4'b1000) begin
        n_err++;
        $display("FAIL bounce cyc %0d: got mode=%b chg=%b rej=%b want mode=10 chg=0 rej=0",
                 j, bus.mode, bus.mode_changed, bus.reject);
      end
    end
    test_idle(8, 2'b10, "bounce_after");
  endtask

  task automatic test_lock();
    do_reset(2);
    bus.lock = 1'b1;
    bus.btn_down = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {2'b10, 1'b0, (j == 6)}) begin
        n_err++;
        $display("FAIL lock cyc %0d: got mode=%b chg=%b rej=%b want mode=10 chg=0 rej=%0d",
                 j, bus.mode, bus.mode_changed, bus.reject, (j == 6));
      end
    end
    bus.lock = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== 4'b1000) begin
        n_err++;
        $display("FAIL unlock_held cyc %0d: got mode=%b chg=%b rej=%b want mode=10 chg=0 rej=0",
                 j, bus.mode, bus.mode_changed, bus.reject);
      end
    end
    test_idle(8, 2'b10, "lock_release");
  endtask

  task automatic test_simultaneous();
    do_reset(2);
    bus.btn_up = 1'b1;
    bus.btn_down = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {2'b10, 1'b0, (j == 6)}) begin
        n_err++;
        $display("FAIL both cyc %0d: got mode=%b chg=%b rej=%b want mode=10 chg=0 rej=%0d",
                 j, bus.mode, bus.mode_changed, bus.reject, (j == 6));
      end
    end
    test_idle(8, 2'b10, "both_release");
  endtask

  task automatic test_down_seq();
    logic [1:0] em;
    do_reset(2);
    bus.btn_down = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      em = (j >= 6) ? 2'b01 : 2'b10;
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {em, (j == 6), 1'b0}) begin
        n_err++;
        $display("FAIL down1 cyc %0d: got mode=%b chg=%b rej=%b want mode=%b chg=%0d rej=0",
                 j, bus.mode, bus.mode_changed, bus.reject, em, (j == 6));
      end
    end
    test_idle(8, 2'b01, "down1_release");
    bus.btn_down = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {2'b01, 1'b0, (j == 6)}) begin
        n_err++;
        $display("FAIL down2_sat cyc %0d: got mode=%b chg=%b rej=%b want mode=01 chg=0 rej=%0d",
                 j, bus.mode, bus.mode_changed, bus.reject, (j == 6));
      end
    end
    test_idle(8, 2'b01, "down2_release");
    // Partial debounce then reset: the pending count must be discarded.
    bus.btn_down = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    bus.btn_down = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.mode !== 2'b10) begin n_err++; $display("FAIL midreset_mode: got %b want 10", bus.mode); end
    reset = 1'b0;
    test_idle(6, 2'b10, "midreset_after");
  endtask

  task automatic test_held_through_reset();
    logic [1:0] em;
    bus.btn_up = 1'b1;
    do_reset(3);
    for (int j = 0; j < 10; j++) begin
      tick();
      em = (j >= 6) ? 2'b11 : 2'b10;
      n_vec++;
      if ({bus.mode, bus.mode_changed, bus.reject} !== {em, (j == 6), 1'b0}) begin
        n_err++;
        $display("FAIL held_reset cyc %0d: got mode=%b chg=%b rej=%b want mode=%b chg=%0d rej=0",
                 j, bus.mode, bus.mode_changed, bus.reject, em, (j == 6));
      end
    end
    test_idle(8, 2'b11, "held_reset_release");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.lock = 1'b0;
    test_reset();
    test_up_press();
    test_bounce();
    test_lock();
    test_simultaneous();
    test_down_seq();
    test_held_through_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
